// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
// Optional parity stage is enabled by defining PISO_PARITY_EN.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: clears on load, counts emitted bits,
// and flags the tick that emits the final data bit.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] count_r;

  // Count register: sized for WIDTH so it never wraps inside a word
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clk_en) begin
      if (clr) begin
        count_r <= {CW{1'b0}};
      end else if (inc) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == LAST_COUNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, LSB first, with sh_en strobes.
// Define PISO_PARITY_EN to append an even-parity tick after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             ser_out,
  output logic             sh_en,
  output logic             done,
  output logic             par_out
);

  state_t           state_r;
  logic [WIDTH-1:0] sreg_r;
  logic             ready_r;
  logic             ser_r;
  logic             sh_r;
  logic             done_r;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             cnt_last_s;

`ifdef PISO_PARITY_EN
  logic                 par_r;
  logic                 parity_r;
  logic [MAX_WIDTH-1:0] din_ext_s;

  // Zero-extend din so the package parity helper works for any WIDTH
  always_comb begin
    din_ext_s              = {MAX_WIDTH{1'b0}};
    din_ext_s[WIDTH-1:0]   = din;
  end
`endif

  assign cnt_clr_s = (state_r == ST_IDLE) && load;
  assign cnt_inc_s = (state_r == ST_SHIFT);

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .clr    (cnt_clr_s),
    .inc    (cnt_inc_s),
    .last   (cnt_last_s)
  );

  // Main FSM and output registers; DONE spends two ticks (pulse, then release)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      sreg_r   <= {WIDTH{1'b0}};
      ready_r  <= 1'b1;
      ser_r    <= 1'b0;
      sh_r     <= 1'b0;
      done_r   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_r    <= 1'b0;
      parity_r <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            sreg_r  <= din;
            ready_r <= 1'b0;
            state_r <= ST_SHIFT;
`ifdef PISO_PARITY_EN
            parity_r <= even_parity(din_ext_s);
`endif
          end
        end
        ST_SHIFT: begin
          ser_r  <= sreg_r[0];
          sh_r   <= 1'b1;
          sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
          if (cnt_last_s) begin
`ifdef PISO_PARITY_EN
            state_r <= ST_PARITY;
`else
            state_r <= ST_DONE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          ser_r   <= parity_r;
          sh_r    <= 1'b0;
          par_r   <= 1'b1;
          state_r <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (!done_r) begin
            done_r <= 1'b1;
            sh_r   <= 1'b0;
            ser_r  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r  <= 1'b0;
`endif
          end else begin
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_r;
  assign ser_out = ser_r;
  assign sh_en   = sh_r;
  assign done    = done_r;
`ifdef PISO_PARITY_EN
  assign par_out = par_r;
`else
  assign par_out = 1'b0;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random
// words, with a tick-indexed output model and a serial-in receiver model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_en;
  logic         load;
  logic [W-1:0] din;
  logic         ready;
  logic         ser_out;
  logic         sh_en;
  logic         done;
  logic         par_out;

  int checks = 0;
  int errors = 0;

  logic         exp_ready;
  logic         exp_ser;
  logic         exp_sh;
  logic         exp_done;
  logic         exp_par;
  logic [W-1:0] rx;

  piso_serializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .load    (load),
    .din     (din),
    .ready   (ready),
    .ser_out (ser_out),
    .sh_en   (sh_en),
    .done    (done),
    .par_out (par_out)
  );

  always #5 clk = ~clk;

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_ser   = 1'b0;
    exp_sh    = 1'b0;
    exp_done  = 1'b0;
    exp_par   = 1'b0;
  endtask

  task automatic check(input string tag);
    checks++;
    assert (ready === exp_ready) else begin
      errors++;
      $error("FAIL %s ready: got %b expected %b", tag, ready, exp_ready);
    end
    checks++;
    assert (ser_out === exp_ser) else begin
      errors++;
      $error("FAIL %s ser_out: got %b expected %b", tag, ser_out, exp_ser);
    end
    checks++;
    assert (sh_en === exp_sh) else begin
      errors++;
      $error("FAIL %s sh_en: got %b expected %b", tag, sh_en, exp_sh);
    end
    checks++;
    assert (done === exp_done) else begin
      errors++;
      $error("FAIL %s done: got %b expected %b", tag, done, exp_done);
    end
    checks++;
    assert (par_out === exp_par) else begin
      errors++;
      $error("FAIL %s par_out: got %b expected %b", tag, par_out, exp_par);
    end
  endtask

  // gap non-tick cycles (outputs must hold, stray loads ignored), then one tick.
  // The receiver model samples DUT outputs just before each tick edge.
  task automatic tick(input int gap, input logic ld, input logic [W-1:0] d);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      clk_en = 1'b0;
      load   = 1'($urandom_range(0, 1));
      din    = W'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("hold");
    end
    @(negedge clk);
    if (sh_en === 1'b1) rx = {ser_out, rx[W-1:1]};
    clk_en = 1'b1;
    load   = ld;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  // Full transfer of one word; noise loads with noise_din are applied on
  // every tick after acceptance and must be ignored.
  task automatic send(input logic [W-1:0] word, input int gap,
                      input logic noise, input logic [W-1:0] noise_din);
    rx = '0;
    tick(gap, 1'b1, word);
    exp_ready = 1'b0;
    check("accept");
    for (int k = 0; k < W; k++) begin
      tick(gap, noise, noise_din);
      exp_ser = word[k];
      exp_sh  = 1'b1;
      check($sformatf("bit%0d", k));
    end
`ifdef PISO_PARITY_EN
    tick(gap, noise, noise_din);
    exp_ser = ^word;
    exp_sh  = 1'b0;
    exp_par = 1'b1;
    check("parity");
`endif
    tick(gap, noise, noise_din);
    exp_ser  = 1'b0;
    exp_sh   = 1'b0;
    exp_done = 1'b1;
    exp_par  = 1'b0;
    check("done");
    tick(gap, noise, noise_din);
    exp_done  = 1'b0;
    exp_ready = 1'b1;
    check("ready_back");
    checks++;
    assert (rx === word) else begin
      errors++;
      $error("FAIL rx_word: got %b expected %b", rx, word);
    end
  endtask

  initial begin
    logic [W-1:0] word;
    int           gap;

    reset  = 1'b0;
    clk_en = 1'b1;
    load   = 1'b0;
    din    = '0;
    rx     = '0;
    set_idle_exp();

    repeat (2) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    reset = 1'b1;

    send(4'b1011, 0, 1'b0, 4'b0000);
    send(4'b1011, 2, 1'b0, 4'b0000);
    send(4'b1011, 0, 1'b1, 4'b0000);

    // Reset during a transfer, with clk_en low and load high at the same time
    rx = '0;
    tick(0, 1'b1, 4'b0110);
    exp_ready = 1'b0;
    check("ab_accept");
    tick(0, 1'b0, 4'b0000);
    exp_ser = 1'b0;
    exp_sh  = 1'b1;
    check("ab_bit0");
    tick(0, 1'b0, 4'b0000);
    exp_ser = 1'b1;
    check("ab_bit1");
    @(negedge clk);
    reset  = 1'b0;
    clk_en = 1'b0;
    load   = 1'b1;
    din    = 4'b1111;
    @(posedge clk);
    #1;
    set_idle_exp();
    check("abort");
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    tick(0, 1'b0, 4'b0000);
    check("post_abort_idle");
    send(4'b1001, 0, 1'b0, 4'b0000);

`ifdef PISO_PARITY_EN
    send(4'b0111, 0, 1'b0, 4'b0000);
`endif

    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 2);
      tick(gap, 1'b0, 4'b0000);
      check("rand_idle");
      word = W'($urandom_range(0, 15));
      send(word, gap, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
